// File: rtl/pa_idu_sb_pkg.sv
// rtl/pa_idu_sb_pkg.sv - shared status encodings and width helpers for the GPR scoreboard
package pa_idu_sb_pkg;

    localparam logic [1:0] SB_IDLE = 2'b00;
    localparam logic [1:0] SB_BUSY = 2'b01;
    localparam logic [1:0] SB_FULL = 2'b11;

    // Port-id width: at least one bit even for a single writeback port
    function automatic int sb_pw(input int wb_ports);
        return (wb_ports > 1) ? $clog2(wb_ports) : 1;
    endfunction

    // Pending-count width: must hold 0..PEND_DEPTH inclusive
    function automatic int sb_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // FIFO pointer width: at least one bit even for a single-entry FIFO
    function automatic int sb_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pa_idu_sb_fifo.sv
// rtl/pa_idu_sb_fifo.sv - in-order FIFO of pending producer port ids with flush
module pa_idu_sb_fifo
    import pa_idu_sb_pkg::*;
#(
    parameter  int WB_PORTS   = 3,
    parameter  int PEND_DEPTH = 2,
    localparam int PW         = sb_pw(WB_PORTS),
    localparam int CW         = sb_cw(PEND_DEPTH),
    localparam int AW         = sb_aw(PEND_DEPTH)
) (
    input  logic                reg_cpuclk,
    input  logic                cpurst_b,
    input  logic [WB_PORTS-1:0] fwd_en,
    input  logic                push_req,
    input  logic [PW-1:0]       push_id,
    input  logic                flush,
    output logic                push_rdy,
    output logic [CW-1:0]       cnt,
    output logic [PW-1:0]       head
);

    logic [PW-1:0] mem_q [PEND_DEPTH];
    logic [PW-1:0] mem_d [PEND_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          empty, full, head_fwd, pop, push;

    // Explicit compare-and-clear so non-power-of-2 depths wrap correctly
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(PEND_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Head decode, retire/accept decisions and next-state computation
    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == CW'(PEND_DEPTH));
        head     = empty ? '0 : mem_q[rd_ptr_q];
        head_fwd = 1'b0;
        for (int i = 0; i < WB_PORTS; i++) begin
            if (head == PW'(i)) begin
                head_fwd = fwd_en[i];
            end
        end
        pop      = ~empty & head_fwd;
        push_rdy = ~full | pop;
        push     = push_req & push_rdy;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_id;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
        cnt = cnt_q;
    end

    // Scoreboard state; reset drops all pending producers at once
    always_ff @(posedge reg_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < PEND_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/pa_idu_gpr_sb_entry.sv
// rtl/pa_idu_gpr_sb_entry.sv - one GPR entry with write mux, bypass and pending-producer scoreboard
module pa_idu_gpr_sb_entry
    import pa_idu_sb_pkg::*;
#(
    parameter  int DW         = 32,
    parameter  int WB_PORTS   = 3,
    parameter  int PEND_DEPTH = 2,
    localparam int PW         = sb_pw(WB_PORTS),
    localparam int CW         = sb_cw(PEND_DEPTH)
) (
    input  logic                   reg_cpuclk,
    input  logic                   cpurst_b,
    input  logic [WB_PORTS-1:0]    wb_wr_en,
    input  logic [WB_PORTS-1:0]    wb_fwd_en,
    input  logic [WB_PORTS*DW-1:0] wb_data,
    input  logic                   sp_wr_en,
    input  logic [DW-1:0]          sp_wr_data,
    input  logic                   warm_up,
    input  logic                   is_vld,
    input  logic [PW-1:0]          is_port,
    input  logic                   is_stall,
    input  logic                   flush,
    output logic                   is_rdy,
    output logic [DW-1:0]          reg_dout,
    output logic                   reg_busy,
    output logic [1:0]             reg_busy_st,
    output logic [CW-1:0]          reg_pend_cnt,
    output logic [PW-1:0]          reg_pend_head
);

    logic [DW-1:0] reg_q, reg_d;
    logic [CW-1:0] cnt;

    // Write-data priority: side port, then lowest writeback port, then warm-up, else hold
    always_comb begin
        reg_d = reg_q;
        if (warm_up) begin
            reg_d = wb_data[0 +: DW];
        end
        for (int i = WB_PORTS - 1; i >= 0; i--) begin
            if (wb_wr_en[i]) begin
                reg_d = wb_data[i*DW +: DW];
            end
        end
        if (sp_wr_en) begin
            reg_d = sp_wr_data;
        end
        reg_dout = reg_d;
    end

    // Architectural register value
    always_ff @(posedge reg_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    pa_idu_sb_fifo #(
        .WB_PORTS   (WB_PORTS),
        .PEND_DEPTH (PEND_DEPTH)
    ) u_sb_fifo (
        .reg_cpuclk (reg_cpuclk),
        .cpurst_b   (cpurst_b),
        .fwd_en     (wb_fwd_en),
        .push_req   (is_vld & ~is_stall),
        .push_id    (is_port),
        .flush      (flush),
        .push_rdy   (is_rdy),
        .cnt        (cnt),
        .head       (reg_pend_head)
    );

    // Hazard status derived from the registered pending count
    always_comb begin
        reg_pend_cnt = cnt;
        reg_busy     = (cnt != '0);
        if (cnt == '0) begin
            reg_busy_st = SB_IDLE;
        end else if (cnt == CW'(PEND_DEPTH)) begin
            reg_busy_st = SB_FULL;
        end else begin
            reg_busy_st = SB_BUSY;
        end
    end

endmodule
